// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the single data_memory port between the processor load/store path
// (port 0) and the serial program/debug loader (port 1). Round-robin
// arbitration, one transaction in flight, all outputs registered, fixed read
// latency, and alignment checking before anything reaches the memory.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  // port 0: processor load/store path
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [1:0]        size0,
  output logic              gnt0,
  output logic              err0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  // port 1: serial program/debug loader
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [1:0]        size1,
  output logic              gnt1,
  output logic              err1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  // data_memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Size encodings understood by data_memory.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  // Counter reload value; RD_LATENCY is limited to 1..4 so two bits suffice.
  localparam logic [1:0] LAT_RELOAD = 2'(RD_LATENCY - 1);

  // A request is rejected if its size is reserved or its address is not
  // naturally aligned for the access width.
  function automatic logic misaligned(input logic [1:0] addr_lsb,
                                      input logic [1:0] size);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lsb[0];
      SZ_WORD: bad = |addr_lsb;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Control state
  state_t      state, state_d;
  logic        last_gnt, last_gnt_d;
  logic [1:0]  lat_cnt, lat_cnt_d;
  logic        cur_port, cur_port_d;
  logic        cur_we, cur_we_d;
  logic        cur_err, cur_err_d;

  // Next values of the registered outputs
  logic              gnt0_d, gnt1_d, err0_d, err1_d;
  logic              rvalid0_d, rvalid1_d;
  logic [DATA_W-1:0] rdata0_d, rdata1_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [1:0]        mem_size_d;
  logic              mem_re_d, mem_we_d;
  logic              busy_d;

  // Arbitration result: a lone requester wins; on contention the port that
  // did not win last time gets the grant.
  logic              win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_size;
  logic              sel_bad;

  assign win       = (req0 && req1) ? ~last_gnt : req1;
  assign sel_we    = win ? we1    : we0;
  assign sel_addr  = win ? addr1  : addr0;
  assign sel_wdata = win ? wdata1 : wdata0;
  assign sel_size  = win ? size1  : size0;
  assign sel_bad   = misaligned(sel_addr[1:0], sel_size);

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every port leaves the block straight from a flop.
  always_comb begin
    state_d     = state;
    last_gnt_d  = last_gnt;
    lat_cnt_d   = lat_cnt;
    cur_port_d  = cur_port;
    cur_we_d    = cur_we;
    cur_err_d   = cur_err;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0;
    rdata1_d    = rdata1;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_size_d  = mem_size;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_d     = ISSUE;
          last_gnt_d  = win;
          cur_port_d  = win;
          cur_we_d    = sel_we;
          cur_err_d   = sel_bad;
          gnt0_d      = ~win;
          gnt1_d      = win;
          err0_d      = sel_bad & ~win;
          err1_d      = sel_bad & win;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_size_d  = sel_size;
          mem_we_d    = ~sel_bad & sel_we;
          mem_re_d    = ~sel_bad & ~sel_we;
        end
      end
      ISSUE: begin
        // Writes and rejected requests finish with the grant itself.
        if (cur_err || cur_we) begin
          state_d = IDLE;
        end else begin
          state_d   = WAIT;
          lat_cnt_d = LAT_RELOAD;
        end
      end
      WAIT: begin
        if (lat_cnt == 2'd0) begin
          state_d = RESP;
          if (cur_port) begin
            rdata1_d  = mem_rdata;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = mem_rdata;
            rvalid0_d = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt - 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // FSM and transaction bookkeeping registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      lat_cnt  <= 2'd0;
      cur_port <= 1'b0;
      cur_we   <= 1'b0;
      cur_err  <= 1'b0;
    end else begin
      state    <= state_d;
      last_gnt <= last_gnt_d;
      lat_cnt  <= lat_cnt_d;
      cur_port <= cur_port_d;
      cur_we   <= cur_we_d;
      cur_err  <= cur_err_d;
    end
  end

  // Registered outputs; reset clears everything, dropping any pending read.
  always_ff @(posedge clock) begin
    if (!reset) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= 2'b00;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gnt0      <= gnt0_d;
      gnt1      <= gnt1_d;
      err0      <= err0_d;
      err1      <= err1_d;
      rvalid0   <= rvalid0_d;
      rvalid1   <= rvalid1_d;
      rdata0    <= rdata0_d;
      rdata1    <= rdata1_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_size  <= mem_size_d;
      mem_re    <= mem_re_d;
      mem_we    <= mem_we_d;
      busy      <= busy_d;
    end
  end

  // Exclusivity of the per-port and memory-side strobes.
  a_gnt_excl: assert property (@(posedge clock) disable iff (!reset)
                               !(gnt0 && gnt1));
  a_mem_excl: assert property (@(posedge clock) disable iff (!reset)
                               !(mem_re && mem_we));
  a_rv_excl:  assert property (@(posedge clock) disable iff (!reset)
                               !(rvalid0 && rvalid1));

endmodule
